// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared requester ids, default widths and read-tag type for the Hack data-RAM arbiter
package hack_mem_pkg;
   localparam logic MST_CPU    = 1'b0;
   localparam logic MST_DMA    = 1'b1;
   localparam int   DEF_ADDR_W = 15;
   localparam int   DEF_DATA_W = 16;
   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: shift register that carries read tags alongside the RAM access until its data returns
module rd_tag_pipe
   import hack_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out
);
   tag_t [DEPTH-1:0] pipe_q, pipe_d;
   // Newest tag enters at stage 0; the oldest leaves from the top stage
   always_comb pipe_d = {pipe_q[DEPTH-2:0], tag_in};
   // Reset drops every in-flight tag so no response is produced for it
   always_ff @(posedge clk) begin
      if (!reset) pipe_q <= '0;
      else pipe_q <= pipe_d;
   end
   assign tag_out = pipe_q[DEPTH-1];
endmodule

// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter: shares the single-port data RAM between the Hack CPU and a DMA engine
module hack_mem_arbiter
   import hack_mem_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]        starve_q, starve_d;
   logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
   logic              dma_win, xfer;
   tag_t              tag_in, tag_out;

   // CPU wins conflicts until DMA has lost LIMIT in a row; the next RAM access and its read tag follow the winner
   always_comb begin
      dma_win     = dma_req && (!cpu_req || starve_q >= LIMIT);
      dma_gnt     = reset && dma_win;
      cpu_gnt     = reset && cpu_req && !dma_win;
      cpu_stall   = cpu_req && !cpu_gnt;
      xfer        = cpu_gnt || dma_gnt;
      starve_d    = (dma_req && !dma_gnt) ? ((starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1) : 4'd0;
      ram_en_d    = xfer;
      ram_we_d    = xfer && (dma_gnt ? dma_we : cpu_we);
      ram_addr_d  = xfer ? (dma_gnt ? dma_addr : cpu_addr) : ram_addr_q;
      ram_wdata_d = xfer ? (dma_gnt ? dma_wdata : cpu_wdata) : ram_wdata_q;
      tag_in.valid = xfer && !ram_we_d;
      tag_in.id    = dma_gnt ? MST_DMA : MST_CPU;
      cpu_rvalid  = reset && tag_out.valid && tag_out.id == MST_CPU;
      dma_rvalid  = reset && tag_out.valid && tag_out.id == MST_DMA;
      cpu_rdata_d = cpu_rvalid ? ram_rdata : cpu_rdata_q;
      dma_rdata_d = dma_rvalid ? ram_rdata : dma_rdata_q;
   end

   // Starvation count, registered RAM issue and per-requester read-data hold
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_q    <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         starve_q    <= starve_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   rd_tag_pipe #(.DEPTH(1 + RD_LATENCY)) u_tags (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_rdata = cpu_rdata_d;
   assign dma_rdata = dma_rdata_d;
endmodule

// File: tb/tb_hack_mem_arbiter.sv
// tb_hack_mem_arbiter: scoreboard bench running two arbiter configurations side by side against a behavioural model
module tb_hack_mem_arbiter;
   logic clk = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [15:0] data;
      int          due;
   } exp_t;

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s inst%0d t=%0t: got %h want %h", nm, inst, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input logic [14:0] a);
      return {a, 1'b0} ^ 16'h5A5B;
   endfunction

   function automatic logic [14:0] rand_addr();
      return 15'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 15'h4000 : 15'h0000);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : h
      localparam int SL = (g == 0) ? 4 : 0;
      localparam int RL = (g == 0) ? 1 : 3;

      logic        reset, cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
      logic        dma_req, dma_we, dma_gnt, dma_rvalid, ram_en, ram_we;
      logic [14:0] cpu_addr, dma_addr, ram_addr;
      logic [15:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, ram_wdata, ram_rdata;
      logic [15:0] rd_sr [RL];
      exp_t        q [$];
      int          cyc = 0;
      bit          started = 1'b0;
      bit          done = 1'b0;

      hack_mem_arbiter #(.ADDR_W(15), .DATA_W(16), .RD_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
         .clk        (clk),
         .reset      (reset),
         .cpu_req    (cpu_req),
         .cpu_we     (cpu_we),
         .cpu_addr   (cpu_addr),
         .cpu_wdata  (cpu_wdata),
         .cpu_gnt    (cpu_gnt),
         .cpu_stall  (cpu_stall),
         .cpu_rvalid (cpu_rvalid),
         .cpu_rdata  (cpu_rdata),
         .dma_req    (dma_req),
         .dma_we     (dma_we),
         .dma_addr   (dma_addr),
         .dma_wdata  (dma_wdata),
         .dma_gnt    (dma_gnt),
         .dma_rvalid (dma_rvalid),
         .dma_rdata  (dma_rdata),
         .ram_en     (ram_en),
         .ram_we     (ram_we),
         .ram_addr   (ram_addr),
         .ram_wdata  (ram_wdata),
         .ram_rdata  (ram_rdata)
      );

      assign ram_rdata = rd_sr[RL-1];

      always @(posedge clk) cyc <= cyc + 1;

      // RAM macro: RL-cycle read latency, junk on the data bus when no read is returning
      initial begin : ram_model
         logic [15:0] mem [0:32767];
         for (int i = 0; i < 32768; i++) mem[i] = init_val(15'(i));
         forever begin
            @(posedge clk);
            if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
            rd_sr[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 16'($urandom);
            for (int i = 1; i < RL; i++) rd_sr[i] <= rd_sr[i-1];
         end
      end

      // Reference model: decides grants from the arbitration rules, tracks memory contents and queues expected reads
      initial begin : model
         logic [15:0] refm [0:32767];
         logic        dw, cw, we, exp_en, exp_we, ram_ok;
         logic [14:0] a, exp_a;
         logic [15:0] wd, exp_wd;
         int          losses;
         for (int i = 0; i < 32768; i++) refm[i] = init_val(15'(i));
         ram_ok = 1'b0; losses = 0;
         exp_en = 1'b0; exp_we = 1'b0; exp_a = '0; exp_wd = '0;
         forever begin
            @(negedge clk);
            if (ram_ok) begin
               chk("ram_en", g, 32'(ram_en), 32'(exp_en));
               chk("ram_we", g, 32'(ram_we), 32'(exp_we));
               chk("ram_addr", g, 32'(ram_addr), 32'(exp_a));
               chk("ram_wdata", g, 32'(ram_wdata), 32'(exp_wd));
            end
            if (!reset) begin
               dw = 1'b0; cw = 1'b0; losses = 0; q.delete();
               exp_en = 1'b0; exp_we = 1'b0; exp_a = '0; exp_wd = '0; ram_ok = 1'b1;
            end else begin
               dw = dma_req && (!cpu_req || losses >= SL);
               cw = cpu_req && !dw;
               losses = (dma_req && !dw) ? ((losses + 1 > SL) ? SL : losses + 1) : 0;
               exp_en = cw || dw;
               exp_we = 1'b0;
               if (cw || dw) begin
                  we = dw ? dma_we : cpu_we;
                  a  = dw ? dma_addr : cpu_addr;
                  wd = dw ? dma_wdata : cpu_wdata;
                  exp_we = we; exp_a = a; exp_wd = wd;
                  if (we) refm[a] = wd;
                  else q.push_back('{id: dw, data: refm[a], due: cyc + 1 + RL});
               end
            end
            chk("cpu_gnt", g, 32'(cpu_gnt), 32'(cw));
            chk("dma_gnt", g, 32'(dma_gnt), 32'(dw));
            chk("cpu_stall", g, 32'(cpu_stall), 32'(cpu_req && !cw));
         end
      end

      // Monitor: every cycle the DUT's response lines must match what the queue says is due now
      initial begin : monitor
         exp_t        e;
         logic [1:0]  exp_v;
         logic [15:0] last_c, last_d;
         bit          pop;
         last_c = '0; last_d = '0;
         forever begin
            @(negedge clk);
            if (!reset) begin
               chk("rvalid_in_reset", g, 32'({cpu_rvalid, dma_rvalid}), 32'd0);
               last_c = '0; last_d = '0; started = 1'b1;
            end else if (started) begin
               pop = q.size() > 0 && q[0].due <= cyc;
               exp_v = 2'b00;
               if (pop) begin
                  e = q.pop_front();
                  exp_v = e.id ? 2'b01 : 2'b10;
                  chk("rdata", g, 32'(e.id ? dma_rdata : cpu_rdata), 32'(e.data));
               end
               chk("rvalid", g, 32'({cpu_rvalid, dma_rvalid}), 32'(exp_v));
               if (!exp_v[1]) chk("cpu_rdata_hold", g, 32'(cpu_rdata), 32'(last_c));
               if (!exp_v[0]) chk("dma_rdata_hold", g, 32'(dma_rdata), 32'(last_d));
               if (exp_v[1]) last_c = e.data;
               if (exp_v[0]) last_d = e.data;
            end
         end
      end

      task automatic op(input bit m, input bit we, input logic [14:0] a, input logic [15:0] d);
         if (m) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; end
         else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
         @(posedge clk); #1;
         cpu_req = 1'b0; dma_req = 1'b0;
      endtask

      // Random requesters that hold their request stable while stalled; prst is resets per thousand cycles
      task automatic drive(input int pc, input int pd, input int pw, input int prst, input int n);
         bit hc, hd;
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hc = cpu_req && !cpu_gnt;
            hd = dma_req && !dma_gnt;
            @(posedge clk); #1;
            reset = $urandom_range(0, 999) >= prst;
            if (!hc) begin
               cpu_req = $urandom_range(0, 99) < pc; cpu_we = $urandom_range(0, 99) < pw;
               cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
            end
            if (!hd) begin
               dma_req = $urandom_range(0, 99) < pd; dma_we = $urandom_range(0, 99) < pw;
               dma_addr = rand_addr(); dma_wdata = 16'($urandom);
            end
         end
      endtask

      task automatic idle(input int n);
         cpu_req = 1'b0; dma_req = 1'b0; reset = 1'b1;
         repeat (n) begin @(posedge clk); #1; end
      endtask

      initial begin : stim
         reset = 1'b0;
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001; cpu_wdata = '0;
         dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0002; dma_wdata = '0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         reset = 1'b1;
         drive(100, 100, 0, 0, 20);
         idle(6);
         op(0, 1, 15'h0010, 16'hBEEF);
         op(0, 0, 15'h0010, 16'h0000);
         op(1, 1, 15'h4000, 16'h1234);
         op(0, 0, 15'h4000, 16'h0000);
         for (int i = 0; i < 4; i++) op(1, 0, 15'(i), 16'h0000);
         idle(6);
         op(0, 0, 15'h0010, 16'h0000);
         reset = 1'b0;
         @(posedge clk); #1;
         reset = 1'b1;
         op(0, 0, 15'h0010, 16'h0000);
         idle(6);
         drive(60, 60, 40, 10, 400);
         idle(8);
         chk("drain", g, 32'(q.size()), 32'd0);
         done = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         if (h[0].done && h[1].done) break;
      end
      if (!(h[0].done && h[1].done)) begin
         err_cnt++;
         $display("FAIL timeout: stimulus did not complete");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
